// File: rtl/neonfox_mem_pkg.sv
// Shared types for the NeonFox memory subsystem: arbiter states, port ids,
// and the small port-indexing helpers used by the arbiter.
package neonfox_mem_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_GAP} arb_state_t;
    typedef enum logic [1:0] {PORT_P1, PORT_P2, PORT_P3} mem_port_t;

    localparam logic [1:0] BURST_LAST = 2'd3;

    // Successor in the p1 -> p2 -> p3 -> p1 ring.
    function automatic mem_port_t next_port(input mem_port_t p);
        case (p)
            PORT_P1: return PORT_P2;
            PORT_P2: return PORT_P3;
            default: return PORT_P1;
        endcase
    endfunction

    function automatic logic port_req(input logic [2:0] r, input mem_port_t p);
        case (p)
            PORT_P1: return r[0];
            PORT_P2: return r[1];
            default: return r[2];
        endcase
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin selector; search begins at the port
// following the previous winner.
module rr_pick3
    import neonfox_mem_pkg::*;
(
    input  logic [2:0] req,
    input  mem_port_t  last,
    output mem_port_t  grant,
    output logic       valid
);

    mem_port_t w_first;
    mem_port_t w_second;

    always_comb begin
        w_first  = next_port(last);
        w_second = next_port(w_first);
        valid    = |req;
        grant    = PORT_P1;
        if (port_req(req, w_first)) begin
            grant = w_first;
        end else if (port_req(req, w_second)) begin
            grant = w_second;
        end else if (port_req(req, last)) begin
            grant = last;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Three-port burst arbiter in front of the single-channel SDRAM controller:
// grants p1/p2/p3 round-robin and steers per-word strobes back to the winner.
module sdram_port_arbiter
    import neonfox_mem_pkg::*;
#(
    parameter int unsigned            ADDR_W  = 24,
    parameter logic [ADDR_W-1:0]      P3_BASE = ADDR_W'(24'hFE0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p1_req,
    input  logic [31:0]       p1_address,
    output logic              p1_ready,
    output logic [1:0]        p1_offset,
    input  logic              p2_req,
    input  logic              p2_wren,
    input  logic [31:0]       p2_address,
    input  logic [15:0]       p2_to_mem,
    output logic              p2_ready,
    output logic [1:0]        p2_offset,
    input  logic              p3_req,
    input  logic              p3_wren,
    input  logic [16:0]       p3_address,
    input  logic [15:0]       p3_to_mem,
    output logic              p3_ready,
    output logic [1:0]        p3_offset,
    output logic [15:0]       from_mem,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_address,
    output logic [15:0]       to_mem,
    input  logic              mem_ready,
    input  logic [1:0]        mem_offset,
    input  logic [15:0]       mem_rdata,
    output logic              proto_err
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    mem_port_t           r_grant;
    mem_port_t           r_last_grant;
    logic                r_mem_wren;
    logic [ADDR_W-1:0]   r_mem_address;
    logic                r_proto_err;

    mem_port_t           w_pick;
    logic                w_pick_valid;
    logic                w_load;
    logic                w_busy;
    logic                w_burst_done;
    logic                w_granted_req;
    logic                w_sel_wren;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [ADDR_W-1:0]   w_p3_sum;
    logic                w_proto_err;
    logic                w_unused;

    rr_pick3 u_pick (
        .req   ({p3_req, p2_req, p1_req}),
        .last  (r_last_grant),
        .grant (w_pick),
        .valid (w_pick_valid)
    );

    assign w_busy       = (r_state == ARB_BUSY);
    assign w_burst_done = w_busy && mem_ready && (mem_offset == BURST_LAST);
    assign w_load       = (r_state == ARB_IDLE) && w_pick_valid;
    assign w_p3_sum     = P3_BASE + ADDR_W'(p3_address);

    // Low address bits are always discarded by the burst alignment.
    assign w_unused = &{1'b0, p1_address, p2_address, p3_address};

    always_comb begin
        w_sel_wren = 1'b0;
        w_sel_addr = '0;
        case (w_pick)
            PORT_P1: w_sel_addr = {p1_address[ADDR_W-1:2], 2'b00};
            PORT_P2: begin
                w_sel_wren = p2_wren;
                w_sel_addr = {p2_address[ADDR_W-1:2], 2'b00};
            end
            default: begin
                w_sel_wren = p3_wren;
                w_sel_addr = {w_p3_sum[ADDR_W-1:2], 2'b00};
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_pick_valid) w_state_nxt = ARB_BUSY;
            ARB_BUSY: if (w_burst_done) w_state_nxt = ARB_GAP;
            ARB_GAP:  w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        case (r_grant)
            PORT_P1: w_granted_req = p1_req;
            PORT_P2: w_granted_req = p2_req;
            default: w_granted_req = p3_req;
        endcase
        w_proto_err = (mem_ready && !w_busy) || (w_busy && !w_granted_req);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ARB_IDLE;
            r_grant       <= PORT_P1;
            r_last_grant  <= PORT_P3;
            r_mem_wren    <= 1'b0;
            r_mem_address <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_proto_err <= w_proto_err;
            if (w_load) begin
                r_grant       <= w_pick;
                r_mem_wren    <= w_sel_wren;
                r_mem_address <= w_sel_addr;
            end
            if (w_burst_done) begin
                r_last_grant <= r_grant;
            end
        end
    end

    always_comb begin
        mem_req     = w_busy;
        mem_wren    = r_mem_wren;
        mem_address = r_mem_address;
        proto_err   = r_proto_err;
        p1_ready    = mem_ready && w_busy && (r_grant == PORT_P1);
        p2_ready    = mem_ready && w_busy && (r_grant == PORT_P2);
        p3_ready    = mem_ready && w_busy && (r_grant == PORT_P3);
        p1_offset   = mem_offset;
        p2_offset   = mem_offset;
        p3_offset   = mem_offset;
        from_mem    = mem_rdata;
        to_mem      = '0;
        if (w_busy) begin
            case (r_grant)
                PORT_P2: to_mem = p2_to_mem;
                PORT_P3: to_mem = p3_to_mem;
                default: to_mem = '0;
            endcase
        end
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Three-port burst arbiter between the NeonFox cache/DMA ports and the single-channel SDRAM controller. It grants one requester at a time from p1 (program cache, read-only), p2 (data cache, read/write-back) and p3 (video/init DMA, read/write). It forwards that requester's 4-word burst request downstream and steers the controller's per-word ready/offset/data back to the granted port. Sits directly between the cache/DMA ports and `sdram_controller`.

## Interface
Parameters:
- `ADDR_W`, 24: downstream word-address width (16M × 16-bit SDRAM).
- `P3_BASE`, 24'hFE0000: word base added to the 17-bit p3 address.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `p1_req` in 1: program cache burst read request.
- `p1_address` in 32: program cache burst address.
- `p1_ready` out 1: per-word strobe to the program cache.
- `p1_offset` out 2: word index within the current burst.
- `p2_req` in 1: data cache burst request.
- `p2_wren` in 1: data cache write (1) / read (0).
- `p2_address` in 32: data cache burst address.
- `p2_to_mem` in 16: data cache write data.
- `p2_ready` out 1: per-word strobe to the data cache.
- `p2_offset` out 2: word index within the current burst.
- `p3_req` in 1: DMA burst request.
- `p3_wren` in 1: DMA write (1) / read (0).
- `p3_address` in 17: DMA burst address.
- `p3_to_mem` in 16: DMA write data.
- `p3_ready` out 1: per-word strobe to the DMA port.
- `p3_offset` out 2: word index within the current burst.
- `from_mem` out 16: read data, shared by all ports; a port treats it as valid only when its own ready is high.
- `mem_req` out 1: burst request to the controller.
- `mem_wren` out 1: burst direction to the controller.
- `mem_address` out ADDR_W: burst-aligned word address to the controller.
- `to_mem` out 16: write data to the controller.
- `mem_ready` in 1: per-word strobe from the controller.
- `mem_offset` in 2: word index from the controller.
- `mem_rdata` in 16: read data from the controller.
- `proto_err` out 1: one-cycle pulse on a protocol violation.

## Operation
- **States.**
  - IDLE: `mem_req`=0.
  - BUSY: `mem_req`=1, granted request forwarded.
  - GAP: `mem_req`=0 for exactly one cycle, so the requester can drop req.
- **IDLE → BUSY.** Taken when any `pN_req`=1. Winner is chosen round-robin: search starts at the port after `last_grant` in order p1 → p2 → p3 → p1. On that edge the arbiter registers:
  - `grant`;
  - `mem_wren` (p1 is always 0);
  - `mem_address`:
    - p1/p2: address[ADDR_W-1:0] with bits [1:0] forced to 0;
    - p3: `P3_BASE` + zero-extended address, bits [1:0] forced to 0, sum truncated to ADDR_W.
- **BUSY → GAP.** Taken on `mem_ready`=1 with `mem_offset`=3. `last_grant` ← `grant`.
- **GAP → IDLE.** Unconditional.
- **Routing (combinational).**
  - `pN_ready` = `mem_ready` & BUSY & (`grant`==N).
  - `pN_offset` = `mem_offset` for every port.
  - `from_mem` = `mem_rdata`.
  - `to_mem` = `p2_to_mem` or `p3_to_mem` per grant; 0 when p1 is granted or the arbiter is idle.
- **Request sampling.** `pN_req`, `pN_address` and `pN_wren` are sampled only on the IDLE → BUSY edge.
  - A requester dropping req during BUSY does not abort the burst; the burst completes.
  - Changing address or wren during BUSY has no effect.
- **`proto_err`.** Pulses the cycle after either:
  - `mem_ready`=1 while not BUSY;
  - the granted `pN_req`=0 during BUSY.
- **Reset values.** All outputs 0; state IDLE; `grant`=p1; `last_grant`=p3, so p1 wins the first tie.

## Timing
- `pN_req` rising before edge k → `mem_req`=1 after edge k; arbitration latency is 1 cycle.
- Word strobes pass through with zero added latency.
- Back-to-back bursts: minimum 2 idle-`mem_req` cycles between bursts (GAP, then the IDLE arbitration cycle).
- `rst` asserted mid-burst: returns immediately to IDLE with `mem_req`=0. The controller owns its own recovery.

## Structure
- Shared package `neonfox_mem_pkg`:
  - `typedef enum logic[1:0] {ARB_IDLE, ARB_BUSY, ARB_GAP} arb_state_t`;
  - `typedef enum logic[1:0] {PORT_P1, PORT_P2, PORT_P3} mem_port_t`;
  - `localparam BURST_LAST = 2'd3`.
- One sub-module, `rr_pick3`: combinational round-robin selector with inputs req[2:0] and last; outputs grant and valid.

## Test plan
- Single p1 read at `p1_address`=32'h0000_1237: `mem_address`=24'h001234, `mem_wren`=0. Controller returns words A0..A3; `p1_ready` pulses 4× with offsets 0..3 and `from_mem`=A0..A3; `p2_ready`/`p3_ready` stay 0.
- p2 write-back to 32'h0040_0008, data D0..D3 driven by offset: `to_mem` equals D[`mem_offset`] on each strobe; `mem_wren`=1.
- p1, p2, p3 all requesting continuously from reset: grant order p1, p2, p3, p1. Gap of 2 cycles with `mem_req`=0 between each burst.
- p3 read at 17'h1_0005 with `P3_BASE`=24'hFE0000: `mem_address`=24'hFF0004.
- `rst` pulse during offset 1 of a p2 burst: `mem_req`=0 and all `pN_ready`=0 while `rst` is high. After release, pending p1 wins first.
- `mem_ready` strobe while IDLE: `proto_err`=1 for exactly one cycle; no `pN_ready` asserted.
